sparse_block_scheduler: RTL



---
 rtl/sparse_block_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sparse_block_scheduler.sv
// sparse_block_scheduler
// Accepts one row of BLOCK_NUM blocks, drops the all-zero blocks and issues
// the remaining ones, one per beat and in ascending index order, to a single
// downstream block MAC. An all-zero row yields one beat flagged as empty.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   data_in*            - row input with valid/ready handshake
//   data_out*           - issued block, its index, last/empty flags, valid/ready
//   skip_count          - saturating count of zero blocks skipped since reset
module sparse_block_scheduler #(
  parameter  int unsigned IN_WIDTH   = 8,
  parameter  int unsigned BLOCK_SIZE = 4,
  parameter  int unsigned BLOCK_NUM  = 4,
  parameter  int unsigned CNT_WIDTH  = 32,
  localparam int unsigned IDX_WIDTH  = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1,
  localparam int unsigned ROW_LEN    = BLOCK_SIZE * BLOCK_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ROW_LEN-1:0][IN_WIDTH-1:0]     data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]  data_out,
  output logic [IDX_WIDTH-1:0]                 data_out_idx,
  output logic                                 data_out_last,
  output logic                                 data_out_empty,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready,
  output logic [CNT_WIDTH-1:0]                 skip_count
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                                r_state;
  logic [ROW_LEN-1:0][IN_WIDTH-1:0]      r_row;
  logic [BLOCK_NUM-1:0]                  r_pend;
  logic                                  r_empty;
  logic [CNT_WIDTH-1:0]                  r_skip;
  logic                                  r_valid;
  logic [IDX_WIDTH-1:0]                  r_idx;
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]   r_data;
  logic                                  r_last;
  logic                                  r_out_empty;

  logic [BLOCK_NUM-1:0]                  w_mask;
  logic [CNT_WIDTH:0]                    w_zero_cnt;
  logic [CNT_WIDTH:0]                    w_skip_sum;
  logic                                  w_hs_out;
  logic                                  w_last_hs;
  logic                                  w_accept;
  state_t                                w_state_n;
  logic [ROW_LEN-1:0][IN_WIDTH-1:0]      w_row_n;
  logic [BLOCK_NUM-1:0]                  w_pend_n;
  logic                                  w_empty_n;
  logic                                  w_valid_n;
  logic [IDX_WIDTH-1:0]                  w_idx_n;
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]   w_data_n;
  logic                                  w_last_n;

  // Per-block non-zero mask and number of zero blocks in the incoming row
  always_comb begin
    w_mask     = '0;
    w_zero_cnt = '0;
    for (int b = 0; b < BLOCK_NUM; b++) begin
      w_mask[b]  = |data_in[b*BLOCK_SIZE +: BLOCK_SIZE];
      w_zero_cnt = w_zero_cnt + (CNT_WIDTH+1)'(!w_mask[b]);
    end
  end

  assign w_skip_sum    = {1'b0, r_skip} + w_zero_cnt;
  assign w_hs_out      = r_valid & data_out_ready;
  assign w_last_hs     = w_hs_out & r_last;
  assign data_in_ready = rst & ((r_state == S_IDLE) | w_last_hs);
  assign w_accept      = data_in_valid & data_in_ready;

  // Next row bookkeeping: retire the issued block, or load a freshly accepted row
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_pend_n  = r_pend;
    w_empty_n = r_empty;
    if (w_hs_out) w_pend_n = r_pend & ~(BLOCK_NUM'(1) << r_idx);
    if (w_last_hs) w_state_n = S_IDLE;
    if (w_accept) begin
      w_state_n = S_ISSUE;
      w_row_n   = data_in;
      w_pend_n  = w_mask;
      w_empty_n = ~|w_mask;
    end
  end

  // Beat contents for the next cycle, derived from the next bookkeeping state
  always_comb begin
    w_valid_n = (w_state_n == S_ISSUE);
    w_idx_n   = '0;
    w_data_n  = '0;
    for (int b = BLOCK_NUM - 1; b >= 0; b--) begin
      if (w_pend_n[b]) w_idx_n = IDX_WIDTH'(b);
    end
    for (int b = 0; b < BLOCK_NUM; b++) begin
      if (w_idx_n == IDX_WIDTH'(b)) w_data_n = w_row_n[b*BLOCK_SIZE +: BLOCK_SIZE];
    end
    // Single remaining bit: pend & (pend-1) clears the lowest set bit
    w_last_n = w_empty_n |
               ((w_pend_n != '0) && ((w_pend_n & (w_pend_n - BLOCK_NUM'(1))) == '0));
    if (!w_valid_n || w_empty_n) w_data_n = '0;
    if (!w_valid_n) begin
      w_idx_n  = '0;
      w_last_n = 1'b0;
    end
  end

  // State, row storage, statistic and registered beat outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_pend      <= '0;
      r_empty     <= 1'b0;
      r_skip      <= '0;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_out_empty <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_row       <= w_row_n;
      r_pend      <= w_pend_n;
      r_empty     <= w_empty_n;
      if (w_accept) begin
        r_skip <= w_skip_sum[CNT_WIDTH] ? '1 : w_skip_sum[CNT_WIDTH-1:0];
      end
      r_valid     <= w_valid_n;
      r_idx       <= w_idx_n;
      r_data      <= w_data_n;
      r_last      <= w_last_n;
      r_out_empty <= w_valid_n & w_empty_n;
    end
  end

  assign data_out       = r_data;
  assign data_out_idx   = r_idx;
  assign data_out_last  = r_last;
  assign data_out_empty = r_out_empty;
  assign data_out_valid = r_valid;
  assign skip_count     = r_skip;

endmodule
